// File: rtl/ag32gbd_pkg.sv
// Shared types and constants for the AG32 Game Boy cart bus host.
// Optional bank-select support is built when AG32GBD_HOST_BANKSEL_EN is defined.
package ag32gbd_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_SETUP  = 3'd1,
    PH_STROBE = 3'd2,
    PH_HOLD   = 3'd3,
    PH_DONE   = 3'd4
  } phase_e;

  localparam logic [2:0]  CART_RAM_WIN  = 3'b101;
  localparam logic [15:0] MBC_BANK_ADDR = 16'h4000;
  localparam logic [4:0]  REG_BANK_ID   = 5'h10;

  // True for addresses inside the cart RAM window A000-BFFF.
  function automatic logic is_cart_ram(input logic [15:0] addr);
    return addr[15:13] == CART_RAM_WIN;
  endfunction

endpackage

// File: rtl/ag32gbd_phase_timer.sv
// Down-counter for one bus phase: loaded on start, pulses expire on the phase's last cycle.
// A load value of 0 is treated as 1.
module ag32gbd_phase_timer (
  input  logic       sys_clock,
  input  logic       sys_resetn,
  input  logic [7:0] load_val,
  input  logic       start,
  output logic       expire
);

  logic [7:0] cnt;
  logic       running;

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt     <= 8'd0;
      running <= 1'b0;
    end else if (start) begin
      // cnt counts the cycles remaining after the current one
      cnt     <= (load_val == 8'd0) ? 8'd0 : load_val - 8'd1;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == 8'd0) running <= 1'b0;
      else             cnt     <= cnt - 8'd1;
    end
  end

  assign expire = running && (cnt == 8'd0);

endmodule

// File: rtl/ag32gbd_host.sv
// Game Boy cart bus initiator: one request -> SETUP/STROBE/HOLD/DONE bus cycle.
// Define AG32GBD_HOST_BANKSEL_EN to add Req_Bank and automatic MBC bank-select writes.
module ag32gbd_host
  import ag32gbd_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 4
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  // Request: accepted on a cycle where Req_Valid && Req_Ready; Req_Ready is high only in IDLE.
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [15:0] Req_Addr,
  input  logic [7:0]  Req_WData,
`ifdef AG32GBD_HOST_BANKSEL_EN
  input  logic [4:0]  Req_Bank,
`endif
  output logic        Rsp_Valid,
  output logic [7:0]  Rsp_RData,
  output logic [15:0] Cart_a,
  output logic [7:0]  Cart_d_out,
  output logic        Cart_d_oe,
  input  logic [7:0]  Cart_d_in,
  output logic        Cart_nRD,
  output logic        Cart_nWR,
  output logic        Cart_nCS,
  output phase_e      dbg_phase
);

  localparam logic [7:0] SETUP_L  = SETUP_CYC[7:0];
  localparam logic [7:0] STROBE_L = STROBE_CYC[7:0];
  localparam logic [7:0] HOLD_L   = HOLD_CYC[7:0];

  phase_e      state, next_state;
  logic        accept;
  logic        expire;
  logic        timer_start;
  logic [7:0]  timer_load;
  logic        bank_cyc;
  logic        busy;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        wr_q;
  logic [7:0]  rdata_q;

  ag32gbd_phase_timer u_timer (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .load_val   (timer_load),
    .start      (timer_start),
    .expire     (expire)
  );

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) state <= PH_IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    timer_load  = 8'd1;
    case (state)
      PH_IDLE:   if (Req_Valid) next_state = PH_SETUP;
      PH_SETUP:  if (expire)    next_state = PH_STROBE;
      PH_STROBE: if (expire)    next_state = PH_HOLD;
      PH_HOLD:   if (expire)    next_state = PH_DONE;
      // an inserted bank-select cycle chains straight into the requested cycle
      PH_DONE:   next_state = bank_cyc ? PH_SETUP : PH_IDLE;
      default:   next_state = PH_IDLE;
    endcase
    if (next_state != state) begin
      case (next_state)
        PH_SETUP:  begin timer_start = 1'b1; timer_load = SETUP_L;  end
        PH_STROBE: begin timer_start = 1'b1; timer_load = STROBE_L; end
        PH_HOLD:   begin timer_start = 1'b1; timer_load = HOLD_L;   end
        default:   ;
      endcase
    end
  end

  assign accept = (state == PH_IDLE) && Req_Valid;
  assign busy   = (state == PH_SETUP) || (state == PH_STROBE) || (state == PH_HOLD);

`ifdef AG32GBD_HOST_BANKSEL_EN
  logic [4:0]  bank_cache;
  logic        cache_valid;
  logic        bank_cyc_q;
  logic [15:0] pend_addr;
  logic [7:0]  pend_wdata;
  logic        pend_write;
  logic        need_bank;

  assign need_bank = is_cart_ram(Req_Addr) && (!cache_valid || (Req_Bank != bank_cache));
  assign bank_cyc  = bank_cyc_q;

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      wr_q        <= 1'b0;
      bank_cache  <= 5'h00;
      cache_valid <= 1'b0;
      bank_cyc_q  <= 1'b0;
      pend_addr   <= 16'h0000;
      pend_wdata  <= 8'h00;
      pend_write  <= 1'b0;
    end else if (accept) begin
      pend_addr  <= Req_Addr;
      pend_wdata <= Req_WData;
      pend_write <= Req_Write;
      bank_cyc_q <= need_bank;
      if (need_bank) begin
        addr_q  <= MBC_BANK_ADDR;
        wdata_q <= {3'b000, Req_Bank};
        wr_q    <= 1'b1;
      end else begin
        addr_q  <= Req_Addr;
        wdata_q <= Req_WData;
        wr_q    <= Req_Write;
      end
    end else if ((state == PH_DONE) && bank_cyc_q) begin
      bank_cache  <= wdata_q[4:0];
      cache_valid <= 1'b1;
      bank_cyc_q  <= 1'b0;
      addr_q      <= pend_addr;
      wdata_q     <= pend_wdata;
      wr_q        <= pend_write;
    end
  end
`else
  assign bank_cyc = 1'b0;

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= Req_Addr;
      wdata_q <= Req_WData;
      wr_q    <= Req_Write;
    end
  end
`endif

  // Read data is sampled on the last strobe cycle; writes report 8'h00.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn)                        rdata_q <= 8'h00;
    else if ((state == PH_STROBE) && expire) rdata_q <= wr_q ? 8'h00 : Cart_d_in;
  end

  always_comb begin
    Req_Ready = (state == PH_IDLE);
    Rsp_Valid = (state == PH_DONE) && !bank_cyc;
    Cart_nCS  = !(busy && is_cart_ram(addr_q));
    Cart_nRD  = !(busy && !wr_q);
    Cart_nWR  = !((state == PH_STROBE) && wr_q);
    Cart_d_oe = busy && wr_q;
  end

  assign Rsp_RData  = rdata_q;
  assign Cart_a     = addr_q;
  assign Cart_d_out = wdata_q;
  assign dbg_phase  = state;

endmodule

// File: tb/tb_ag32gbd_host.sv
// Directed bench for ag32gbd_host with default timing (4/8/4); bank-select test runs
// only when AG32GBD_HOST_BANKSEL_EN is defined.
module tb_ag32gbd_host;
  import ag32gbd_pkg::*;

  logic        sys_clock = 1'b0;
  logic        sys_resetn;
  logic        Req_Valid, Req_Ready, Req_Write;
  logic [15:0] Req_Addr;
  logic [7:0]  Req_WData;
`ifdef AG32GBD_HOST_BANKSEL_EN
  logic [4:0]  Req_Bank;
`endif
  logic        Rsp_Valid;
  logic [7:0]  Rsp_RData;
  logic [15:0] Cart_a;
  logic [7:0]  Cart_d_out, Cart_d_in;
  logic        Cart_d_oe, Cart_nRD, Cart_nWR, Cart_nCS;
  phase_e      dbg_phase;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the last run_access
  int         r_lat, r_rsp, r_ncs, r_nrd, r_nwr, r_oe;
  int         r_first_ncs, r_first_nrd, r_first_nwr, r_addr_bad, r_dout_bad;
  logic       r_ready;
  logic [7:0] r_rdata;

  ag32gbd_host dut (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Write  (Req_Write),
    .Req_Addr   (Req_Addr),
    .Req_WData  (Req_WData),
`ifdef AG32GBD_HOST_BANKSEL_EN
    .Req_Bank   (Req_Bank),
`endif
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_RData  (Rsp_RData),
    .Cart_a     (Cart_a),
    .Cart_d_out (Cart_d_out),
    .Cart_d_oe  (Cart_d_oe),
    .Cart_d_in  (Cart_d_in),
    .Cart_nRD   (Cart_nRD),
    .Cart_nWR   (Cart_nWR),
    .Cart_nCS   (Cart_nCS),
    .dbg_phase  (dbg_phase)
  );

  // clock / reset
  always #5 sys_clock = ~sys_clock;

  // Driver: one access; cycle c = 1 is the first cycle after the acceptance edge.
  // Cart_d_in carries din only on cycle cap_c, junk otherwise.
  task automatic run_access(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] din, input int win, input int cap_c);
    r_lat = -1; r_rsp = 0; r_ncs = 0; r_nrd = 0; r_nwr = 0; r_oe = 0; r_rdata = 8'hxx;
    r_first_ncs = -1; r_first_nrd = -1; r_first_nwr = -1; r_addr_bad = 0; r_dout_bad = 0;
    @(negedge sys_clock);
    r_ready = Req_Ready;
    Req_Valid = 1'b1; Req_Write = wr; Req_Addr = addr; Req_WData = wd; Cart_d_in = 8'hEE;
    @(posedge sys_clock);
    #1;
    Req_Valid = 1'b0; Req_Write = ~wr; Req_Addr = 16'h0000; Req_WData = 8'hFF;
    for (int c = 1; c <= win; c++) begin
      @(negedge sys_clock);
      if (!Cart_nCS) begin r_ncs++; if (r_first_ncs < 0) r_first_ncs = c; end
      if (!Cart_nRD) begin r_nrd++; if (r_first_nrd < 0) r_first_nrd = c; end
      if (!Cart_nWR) begin r_nwr++; if (r_first_nwr < 0) r_first_nwr = c; end
      if (Cart_d_oe) begin r_oe++; if (Cart_d_out !== wd) r_dout_bad++; end
      if (c <= 16 && Cart_a !== addr) r_addr_bad++;
      if (Rsp_Valid) begin r_rsp++; if (r_lat < 0) begin r_lat = c; r_rdata = Rsp_RData; end end
      Cart_d_in = (c == cap_c) ? din : 8'hEE;
    end
  endtask

  task automatic test_reset;
    sys_resetn = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = 16'h0; Req_WData = 8'h0;
    Cart_d_in = 8'h00;
`ifdef AG32GBD_HOST_BANKSEL_EN
    Req_Bank = 5'h00;
`endif
    repeat (3) @(negedge sys_clock);
    n_cmp++;
    if ({Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe, Rsp_Valid} !== 5'b11100) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 11100", {Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe, Rsp_Valid});
    end
    n_cmp++;
    if ({Cart_a, Cart_d_out, Rsp_RData} !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {Cart_a, Cart_d_out, Rsp_RData});
    end
    sys_resetn = 1'b1;
    @(negedge sys_clock);
    n_cmp++;
    if (Req_Ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", Req_Ready); end
  endtask

  task automatic test_write_ram;
    run_access(1'b1, 16'hA000, 8'h01, 8'h00, 20, 12);
    n_cmp++; if (r_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ram_ready: got %b want 1", r_ready); end
    n_cmp++; if (r_lat != 17) begin n_bad++; $display("FAIL wr_ram_latency: got %0d want 17", r_lat); end
    n_cmp++; if (r_rsp != 1) begin n_bad++; $display("FAIL wr_ram_rsp_count: got %0d want 1", r_rsp); end
    n_cmp++; if (r_ncs != 16 || r_first_ncs != 1) begin
      n_bad++; $display("FAIL wr_ram_ncs: got %0d cyc from %0d want 16 from 1", r_ncs, r_first_ncs); end
    n_cmp++; if (r_nwr != 8 || r_first_nwr != 5) begin
      n_bad++; $display("FAIL wr_ram_nwr: got %0d cyc from %0d want 8 from 5", r_nwr, r_first_nwr); end
    n_cmp++; if (r_oe != 16 || r_dout_bad != 0) begin
      n_bad++; $display("FAIL wr_ram_data: got oe %0d bad %0d want oe 16 bad 0", r_oe, r_dout_bad); end
    n_cmp++; if (r_addr_bad != 0 || r_nrd != 0) begin
      n_bad++; $display("FAIL wr_ram_addr_nrd: got addr_bad %0d nrd %0d want 0 0", r_addr_bad, r_nrd); end
    n_cmp++; if (r_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_ram_rdata: got %h want 00", r_rdata); end
    // idle bus afterwards keeps the last address
    n_cmp++;
    if ({Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe} !== 4'b1110 || Cart_a !== 16'hA000) begin
      n_bad++; $display("FAIL wr_ram_idle: got %b a=%h want 1110 a=a000", {Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe}, Cart_a);
    end
  endtask

  task automatic test_read_ram;
    run_access(1'b0, 16'hA123, 8'h00, 8'h5A, 20, 12);
    n_cmp++; if (r_lat != 17 || r_rsp != 1) begin
      n_bad++; $display("FAIL rd_ram_rsp: got lat %0d cnt %0d want 17 1", r_lat, r_rsp); end
    n_cmp++; if (r_rdata !== 8'h5A) begin n_bad++; $display("FAIL rd_ram_rdata: got %h want 5a", r_rdata); end
    n_cmp++; if (r_nrd != 16 || r_first_nrd < 0 || r_first_nrd > r_first_ncs) begin
      n_bad++; $display("FAIL rd_ram_nrd: got %0d cyc from %0d (ncs from %0d) want 16 from <=ncs", r_nrd, r_first_nrd, r_first_ncs); end
    n_cmp++; if (r_ncs != 16 || r_nwr != 0 || r_oe != 0) begin
      n_bad++; $display("FAIL rd_ram_strobes: got ncs %0d nwr %0d oe %0d want 16 0 0", r_ncs, r_nwr, r_oe); end
    n_cmp++; if (r_addr_bad != 0) begin n_bad++; $display("FAIL rd_ram_addr: got %0d bad cycles want 0", r_addr_bad); end
  endtask

  task automatic test_write_rom;
    run_access(1'b1, 16'h2000, 8'h07, 8'h00, 20, 12);
    n_cmp++; if (r_ncs != 0) begin n_bad++; $display("FAIL wr_rom_ncs: got %0d low cycles want 0", r_ncs); end
    n_cmp++; if (r_nwr != 8 || r_first_nwr != 5) begin
      n_bad++; $display("FAIL wr_rom_nwr: got %0d cyc from %0d want 8 from 5", r_nwr, r_first_nwr); end
    n_cmp++; if (r_lat != 17 || r_dout_bad != 0) begin
      n_bad++; $display("FAIL wr_rom_rsp: got lat %0d dout_bad %0d want 17 0", r_lat, r_dout_bad); end
  endtask

  task automatic test_reset_mid_strobe;
    int rsp_seen;
    rsp_seen = 0;
    @(negedge sys_clock);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 16'hA000; Req_WData = 8'h33;
    @(posedge sys_clock);
    #1 Req_Valid = 1'b0;
    repeat (8) @(negedge sys_clock);
    n_cmp++; if (Cart_nWR !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre: got nWR %b want 0", Cart_nWR); end
    #2 sys_resetn = 1'b0;
    #1;
    n_cmp++;
    if ({Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe, Rsp_Valid} !== 5'b11100 || Cart_a !== 16'h0) begin
      n_bad++; $display("FAIL rst_mid_force: got %b a=%h want 11100 a=0000", {Cart_nRD, Cart_nWR, Cart_nCS, Cart_d_oe, Rsp_Valid}, Cart_a);
    end
    repeat (2) @(negedge sys_clock);
    sys_resetn = 1'b1;
    @(negedge sys_clock);
    n_cmp++; if (Req_Ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", Req_Ready); end
    for (int c = 0; c < 25; c++) begin
      @(negedge sys_clock);
      if (Rsp_Valid) rsp_seen++;
    end
    n_cmp++; if (rsp_seen != 0) begin n_bad++; $display("FAIL rst_mid_no_rsp: got %0d responses want 0", rsp_seen); end
  endtask

  task automatic test_back_to_back;
    int acc, run, gap, c;
    logic drop, prev_oe;
    int rsp_c[$];
    int runs[$];
    int gaps[$];
    acc = 0; run = 0; gap = 0; drop = 1'b0; prev_oe = 1'b0;
    @(negedge sys_clock);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 16'h2000; Req_WData = 8'h44;
    for (c = 0; c < 70; c++) begin
      if (c > 0) @(negedge sys_clock);
      if (Rsp_Valid) rsp_c.push_back(c);
      if (Cart_d_oe) begin
        if (!prev_oe && runs.size() > 0) gaps.push_back(gap);
        run++;
      end else begin
        if (prev_oe) begin runs.push_back(run); run = 0; gap = 0; end
        gap++;
      end
      prev_oe = Cart_d_oe;
      if (drop) Req_Valid = 1'b0;
      if (Req_Valid && Req_Ready) begin acc++; if (acc == 3) drop = 1'b1; end
    end
    Req_Valid = 1'b0;
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    n_cmp++;
    if (rsp_c.size() != 3) begin
      n_bad++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_c.size());
    end else if (rsp_c[1] - rsp_c[0] != 18 || rsp_c[2] - rsp_c[1] != 18) begin
      n_bad++; $display("FAIL b2b_rsp_spacing: got %0d %0d want 18 18", rsp_c[1] - rsp_c[0], rsp_c[2] - rsp_c[1]);
    end
    n_cmp++;
    if (runs.size() != 3 || gaps.size() != 2) begin
      n_bad++; $display("FAIL b2b_bus_runs: got %0d runs %0d gaps want 3 2", runs.size(), gaps.size());
    end else if (runs[0] != 16 || runs[1] != 16 || runs[2] != 16 || gaps[0] != 2 || gaps[1] != 2) begin
      n_bad++; $display("FAIL b2b_bus_shape: got runs %0d %0d %0d gaps %0d %0d want 16x3 gaps 2 2",
                        runs[0], runs[1], runs[2], gaps[0], gaps[1]);
    end
  endtask

`ifdef AG32GBD_HOST_BANKSEL_EN
  task automatic test_banksel;
    Req_Bank = REG_BANK_ID;
    // first read: bank write (17 cycles incl. its DONE) then the read; data captured on cycle 29
    run_access(1'b0, 16'hA000, 8'h00, 8'h66, 40, 29);
    n_cmp++; if (r_lat != 34 || r_rsp != 1) begin
      n_bad++; $display("FAIL bank_first_rsp: got lat %0d cnt %0d want 34 1", r_lat, r_rsp); end
    n_cmp++; if (r_nwr != 8 || r_first_nwr != 5 || r_rdata !== 8'h66) begin
      n_bad++; $display("FAIL bank_first_cycle: got nwr %0d from %0d rdata %h want 8 from 5 66", r_nwr, r_first_nwr, r_rdata); end
    run_access(1'b0, 16'hA000, 8'h00, 8'h77, 20, 12);
    n_cmp++; if (r_lat != 17 || r_rsp != 1 || r_nwr != 0 || r_rdata !== 8'h77) begin
      n_bad++; $display("FAIL bank_second: got lat %0d cnt %0d nwr %0d rdata %h want 17 1 0 77", r_lat, r_rsp, r_nwr, r_rdata); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_ram;
    test_read_ram;
    test_write_rom;
    test_reset_mid_strobe;
    test_back_to_back;
`ifdef AG32GBD_HOST_BANKSEL_EN
    test_banksel;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
